// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller with edge-detected
// request latching, a writable enable mask and a raise/ack/end handshake.
module irq_controller #(
  parameter int NUM_SRC            = 4,
  parameter int ID_W               = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter logic [NUM_SRC-1:0] MASK_RESET = '1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               reset_irq,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] prev_req;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    winner;
  logic               ack_take;

  assign rise     = src_req & ~prev_req;
  assign eligible = pending & mask;
  assign ack_take = (state == S_ASSERT) && irq_ack;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eligible[i-1]) begin
        winner = ID_W'(i - 1);
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    if (ack_take) begin
      ack_clr[irq_id] = 1'b1;
    end
  end

  // Rising edges are OR-ed in after the ack clear so a same-cycle set wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_req <= '0;
      pending  <= '0;
      mask     <= MASK_RESET;
    end else begin
      prev_req <= src_req;
      pending  <= (pending & ~ack_clr) | rise;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      irq_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|eligible) begin
            state  <= S_ASSERT;
            irq_id <= winner;
          end
        end
        S_ASSERT: begin
          if (irq_ack) begin
            state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (reset_irq) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign irq  = (state == S_ASSERT);
  assign busy = (state == S_ASSERT) || (state == S_SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NUM_SRC = 4).
module tb_irq_controller;

  logic       clock;
  logic       reset;
  logic [3:0] src_req;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       irq_ack;
  logic       reset_irq;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       busy;

  int ncmp = 0;
  int nerr = 0;

  irq_controller #(
    .NUM_SRC   (4),
    .ID_W      (2),
    .MASK_RESET(4'b1111)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .src_req   (src_req),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .irq_ack   (irq_ack),
    .reset_irq (reset_irq),
    .irq       (irq),
    .irq_id    (irq_id),
    .pending   (pending),
    .mask      (mask),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    src_req    = 4'($urandom);
    mask_we    = 1'b1;
    mask_wdata = 4'($urandom);
    irq_ack    = 1'($urandom);
    reset_irq  = 1'($urandom);

    // 1. reset with random inputs
    step();
    step();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_mask", 32'(mask), 32'hf);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    src_req    = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    reset_irq  = 1'b0;
    #1 reset   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_no_irq", 32'(irq), 32'd0);
    end

    // 2. single request on source 2
    src_req = 4'b0100;
    step();
    src_req = 4'b0000;
    check("s2_pending", 32'(pending), 32'h4);
    check("s2_irq_early", 32'(irq), 32'd0);
    step();
    check("s2_irq", 32'(irq), 32'd1);
    check("s2_id", 32'(irq_id), 32'd2);
    check("s2_busy", 32'(busy), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("s2_ack_irq", 32'(irq), 32'd0);
    check("s2_ack_pending", 32'(pending), 32'h0);
    check("s2_svc_busy", 32'(busy), 32'd1);
    reset_irq = 1'b1;
    step();
    reset_irq = 1'b0;
    check("s2_end_busy", 32'(busy), 32'd0);

    // 3. priority between sources 1 and 3
    src_req = 4'b1010;
    step();
    src_req = 4'b0000;
    check("p_pending", 32'(pending), 32'ha);
    step();
    check("p_first_irq", 32'(irq), 32'd1);
    check("p_first_id", 32'(irq_id), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("p_pending_after_ack", 32'(pending), 32'h8);
    reset_irq = 1'b1;
    step();
    reset_irq = 1'b0;
    check("p_gap_irq", 32'(irq), 32'd0);
    check("p_gap_busy", 32'(busy), 32'd0);
    step();
    check("p_second_irq", 32'(irq), 32'd1);
    check("p_second_id", 32'(irq_id), 32'd3);
    irq_ack = 1'b1;
    step();
    irq_ack   = 1'b0;
    reset_irq = 1'b1;
    step();
    reset_irq = 1'b0;
    check("p_done_pending", 32'(pending), 32'h0);

    // 4. masking
    mask_we    = 1'b1;
    mask_wdata = 4'b1110;
    step();
    mask_we = 1'b0;
    check("m_mask", 32'(mask), 32'he);
    src_req = 4'b0001;
    step();
    src_req = 4'b0000;
    check("m_pending", 32'(pending), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("m_masked_no_irq", 32'(irq), 32'd0);
    end
    mask_we    = 1'b1;
    mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
    check("m_unmask_irq_early", 32'(irq), 32'd0);
    step();
    check("m_unmask_irq", 32'(irq), 32'd1);
    check("m_unmask_id", 32'(irq_id), 32'd0);
    // a mask write in ASSERT does not withdraw the request
    mask_we    = 1'b1;
    mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    check("m_commit_irq", 32'(irq), 32'd1);
    check("m_commit_id", 32'(irq_id), 32'd0);
    irq_ack = 1'b1;
    step();
    irq_ack    = 1'b0;
    reset_irq  = 1'b1;
    mask_we    = 1'b1;
    mask_wdata = 4'b1111;
    step();
    reset_irq = 1'b0;
    mask_we   = 1'b0;
    check("m_done_busy", 32'(busy), 32'd0);

    // 5. set wins over ack clear
    src_req = 4'b0100;
    step();
    src_req = 4'b0000;
    step();
    check("sw_id", 32'(irq_id), 32'd2);
    irq_ack = 1'b1;
    src_req = 4'b0100;
    step();
    irq_ack = 1'b0;
    src_req = 4'b0000;
    check("sw_svc_busy", 32'(busy), 32'd1);
    check("sw_svc_irq", 32'(irq), 32'd0);
    check("sw_pending", 32'(pending), 32'h4);
    reset_irq = 1'b1;
    step();
    reset_irq = 1'b0;
    step();
    check("sw_reraise_irq", 32'(irq), 32'd1);
    check("sw_reraise_id", 32'(irq_id), 32'd2);
    // ack and reset_irq together in ASSERT: ack taken, reset_irq ignored
    irq_ack   = 1'b1;
    reset_irq = 1'b1;
    step();
    irq_ack   = 1'b0;
    reset_irq = 1'b0;
    check("both_busy", 32'(busy), 32'd1);
    check("both_irq", 32'(irq), 32'd0);
    check("both_pending", 32'(pending), 32'h0);
    reset_irq = 1'b1;
    step();
    reset_irq = 1'b0;
    check("both_end_busy", 32'(busy), 32'd0);

    // 6. asynchronous reset mid-service
    src_req = 4'b1010;
    step();
    src_req = 4'b0000;
    step();
    check("ar_id", 32'(irq_id), 32'd1);
    irq_ack = 1'b1;
    src_req = 4'b0010;
    step();
    irq_ack = 1'b0;
    src_req = 4'b0000;
    check("ar_svc_busy", 32'(busy), 32'd1);
    check("ar_svc_pending", 32'(pending), 32'ha);
    #2 reset = 1'b0;
    #1;
    check("ar_irq", 32'(irq), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_pending", 32'(pending), 32'h0);
    check("ar_mask", 32'(mask), 32'hf);
    check("ar_id0", 32'(irq_id), 32'd0);

    // release with a request already held high counts as a rise
    src_req = 4'b0001;
    step();
    reset = 1'b1;
    step();
    check("rel_pending", 32'(pending), 32'h1);
    step();
    check("rel_irq", 32'(irq), 32'd1);
    check("rel_id", 32'(irq_id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Prioritised interrupt controller that sits between the I/O drivers (keyboard, VGA and future devices) and the CPU controlpath. It turns device request lines into latched pending interrupts, applies a software-writable enable mask, and picks the lowest-index enabled pending source. It drives the single `irq` line into the datapath and controlpath, and runs a three-state handshake: raise, acknowledge, end-of-service via `reset_irq`. Only one interrupt is in service at a time; nesting is not supported.

## Interface
- `NUM_SRC`, 4: number of interrupt sources, 1..16.
- `ID_W`, `$clog2(NUM_SRC)` (minimum 1): width of `irq_id`.
- `MASK_RESET`, all ones (`NUM_SRC` bits): reset value of the enable mask.

- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `src_req`  in  NUM_SRC  device request levels, synchronous to `clock`. A rising edge requests an interrupt.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  NUM_SRC  new mask value; bit i = 1 enables source i.
- `irq_ack`  in  1  one-cycle pulse from the controlpath when it takes the interrupt (vector fetch).
- `reset_irq`  in  1  one-cycle pulse from the controlpath at end of service (return-from-interrupt).
- `irq`  out  1  interrupt request to the CPU.
- `irq_id`  out  ID_W  index of the source being raised or serviced.
- `pending`  out  NUM_SRC  latched pending bits, for debug LEDs and status reads.
- `mask`  out  NUM_SRC  current enable mask.
- `busy`  out  1  high in ASSERT or SERVICE.

## Operation
- **Edge detect:** `prev_req` is registered every cycle. `rise = src_req & ~prev_req`. Each rising bit sets the matching `pending` bit on that edge.
- **Pending clear:** `pending[irq_id]` clears on the edge where `irq_ack` is accepted in ASSERT.
  - If the same source's rise occurs in that same cycle, set wins and the bit stays 1.
  - Pending bits for other sources are never cleared by the controller.
- **Mask:** when `mask_we` = 1, the mask is loaded with `mask_wdata` on that edge.
  - Masking does not clear `pending`; a masked pending bit becomes eligible once it is unmasked.
- **Eligibility:** `eligible = pending & mask`. The winner is the lowest set index (source 0 has highest priority).
- **FSM states:**
  - **IDLE:** `irq` = 0. If `eligible` ≠ 0, go to ASSERT and latch `irq_id` = winner on that edge.
  - **ASSERT:** `irq` = 1 and `irq_id` is held stable.
    - On `irq_ack`: go to SERVICE and clear `pending[irq_id]`.
    - Once ASSERT is entered the request is committed; a mask write does not withdraw it.
    - `reset_irq` is ignored in this state.
  - **SERVICE:** `irq` = 0 and `irq_id` is held. On `reset_irq`, go to IDLE. `irq_ack` is ignored.
  - Any undefined state encoding returns to IDLE.
- **Simultaneous `irq_ack` and `reset_irq` in ASSERT:** ack is taken and `reset_irq` is ignored.
- **Reset (asynchronous, at any time, including mid-service):** state = IDLE, `pending` = 0, `prev_req` = 0, `mask` = MASK_RESET, `irq_id` = 0. Consequently `irq` = 0, `busy` = 0 and `pending` = 0 at the output.
- **Release with request held high:** if `src_req` is already high when reset is released, that counts as a rising edge on the first clock.
- **Outputs:** all outputs are registered or decoded from state only; there is no combinational path from inputs to `irq`.

## Timing
- **Request to `irq`:** with `src_req[i]` rising before edge k, `pending[i]` is high after k and `irq` is high after k+1. Latency is 2 clocks, provided the controller is IDLE and the source is enabled.
- **Ack:** `irq_ack` sampled at edge j in ASSERT gives `irq` low and the pending bit clear after j.
- **End of service:** `reset_irq` sampled at edge m in SERVICE gives IDLE after m. The next `irq` rises after m+1 at the earliest.
- **Back-to-back:** one idle cycle of `irq` = 0 separates consecutive interrupts.
- **Mask write:** `mask_we` at edge k affects winner selection from edge k+1.
- **Throughput:** at most one rising edge per source is recorded while that source is pending. Further edges before it is acked merge into the same pending bit.

## Test plan
(All scenarios use `NUM_SRC` = 4.)
1. **Reset:** hold `reset` = 0 with random inputs. Expect `irq` = 0, `pending` = 0000, `mask` = 1111, `busy` = 0. Release with `src_req` = 0000: no `irq` for 20 cycles.
2. **Single request:** pulse `src_req[2]` for 1 cycle.
   - `pending` = 0100 after 1 clock; `irq` = 1 and `irq_id` = 2 after 2 clocks.
   - `irq_ack` gives `irq` = 0 and `pending` = 0000.
   - `reset_irq` gives `busy` = 0.
3. **Priority:** raise `src_req` bits 3 and 1 on the same cycle.
   - First service: `irq_id` = 1, then `irq_ack` and `reset_irq`.
   - Second service: `irq_id` = 3, raised 2 cycles after `reset_irq` (one idle cycle between them).
4. **Masking:** write `mask` = 1110, then pulse `src_req[0]`.
   - `pending` = 0001 and no `irq` for 10 cycles.
   - Write `mask` = 1111: `irq` with `irq_id` = 0 two clocks later.
5. **Set wins:** in ASSERT with `irq_id` = 2, pulse `irq_ack` and a new rise on `src_req[2]` in the same cycle. Expect SERVICE with `pending[2]` = 1 remaining; after `reset_irq`, `irq_id` = 2 is raised again.
6. **Reset mid-service:** assert `reset` asynchronously (mid-cycle) in SERVICE with `pending` = 1010. All outputs return to their reset values immediately, before the next clock edge.
